// File: rtl/pov_column_reader.sv
// POV column reader: fetches one column word from a 2-cycle RAM and shifts it MSB-first to the LED chain.
// Optional blanking input is enabled by defining POV_READER_BLANK_EN.
module pov_column_reader #(
    parameter int DAT_WIDTH  = 36,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_COLS   = 128,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  col_tick,
    input  logic                  index_tick,
    output logic [ADDR_WIDTH-1:0] rdaddress,
    input  logic [DAT_WIDTH-1:0]  q,
`ifdef POV_READER_BLANK_EN
    input  logic                  blank,
`endif
    output logic                  led_sdata,
    output logic                  led_sclk,
    output logic                  led_latch,
    output logic                  busy,
    output logic                  overrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DAT_WIDTH > 1) ? $clog2(DAT_WIDTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(NUM_COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_F1,
        S_F2,
        S_LOAD,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_col_ptr;
    logic [ADDR_WIDTH-1:0] r_rdaddress;
    logic [DAT_WIDTH-1:0]  r_shreg;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic                  r_pending;
    logic                  r_sdata;
    logic                  r_sclk;
    logic                  r_latch;
    logic                  r_busy;
    logic                  r_overrun;

    logic                  w_phase_end;
    logic                  w_shift_done;
    logic [DAT_WIDTH-1:0]  w_load_word;

    assign w_phase_end  = (r_div_cnt == DIV_W'(CLK_DIV - 1));
    assign w_shift_done = w_phase_end && r_sclk && (r_bit_cnt == BIT_W'(DAT_WIDTH - 1));

`ifdef POV_READER_BLANK_EN
    assign w_load_word = blank ? '0 : q;
`else
    assign w_load_word = q;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: next state defaults to the current state so no path leaves w_next unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (col_tick) w_next = S_F1;
            S_F1:    w_next = S_F2;
            S_F2:    w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_shift_done) w_next = S_LATCH;
            S_LATCH: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_col_ptr   <= '0;
            r_rdaddress <= '0;
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_div_cnt   <= '0;
            r_pending   <= 1'b0;
            r_sdata     <= 1'b0;
            r_sclk      <= 1'b0;
            r_latch     <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= col_tick && (r_state != S_IDLE);
            r_latch   <= (r_state == S_SHIFT) && w_shift_done;
            // An index seen mid-column is deferred so the column in flight is not disturbed.
            if (index_tick && (r_state != S_IDLE) && (r_state != S_LATCH))
                r_pending <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (index_tick) r_col_ptr <= '0;
                    if (col_tick) begin
                        r_rdaddress <= index_tick ? '0 : r_col_ptr;
                        r_busy      <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_shreg   <= w_load_word;
                    r_sdata   <= w_load_word[DAT_WIDTH-1];
                    r_sclk    <= 1'b0;
                    r_bit_cnt <= '0;
                    r_div_cnt <= '0;
                end
                S_SHIFT: begin
                    if (!w_phase_end) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else if (w_shift_done) begin
                            r_sclk  <= 1'b0;
                            r_sdata <= 1'b0;
                        end else begin
                            r_sclk    <= 1'b0;
                            r_shreg   <= r_shreg << 1;
                            r_sdata   <= r_shreg[DAT_WIDTH-2];
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                S_LATCH: begin
                    r_busy    <= 1'b0;
                    r_pending <= 1'b0;
                    if (r_pending || index_tick) r_col_ptr <= '0;
                    else if (r_col_ptr == LAST_COL) r_col_ptr <= '0;
                    else r_col_ptr <= r_col_ptr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign rdaddress = r_rdaddress;
    assign led_sdata = r_sdata;
    assign led_sclk  = r_sclk;
    assign led_latch = r_latch;
    assign busy      = r_busy;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_pov_column_reader.sv
// Self-checking bench for pov_column_reader: 2-cycle RAM model, column-level reference model.
// Blank scenario runs only when POV_READER_BLANK_EN is defined.
module tb_pov_column_reader;

    localparam int DAT_WIDTH  = 36;
    localparam int ADDR_WIDTH = 7;
    localparam int NUM_COLS   = 4;
    localparam int CLK_DIV    = 4;
    localparam int COL_CYCLES = 4 + 2 * CLK_DIV * DAT_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  col_tick;
    logic                  index_tick;
    logic [ADDR_WIDTH-1:0] rdaddress;
    logic [DAT_WIDTH-1:0]  q;
    logic                  blank;
    logic                  led_sdata;
    logic                  led_sclk;
    logic                  led_latch;
    logic                  busy;
    logic                  overrun;

    logic [DAT_WIDTH-1:0]  mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] ram_addr;

    int checks   = 0;
    int failures = 0;
    int exp_ptr  = 0;

    always #5 clk = ~clk;

    // Frame-buffer RAM: address register then output register.
    always @(posedge clk) begin
        ram_addr <= rdaddress;
        q        <= mem[ram_addr];
    end

    pov_column_reader #(
        .DAT_WIDTH (DAT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_COLS  (NUM_COLS),
        .CLK_DIV   (CLK_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .col_tick  (col_tick),
        .index_tick(index_tick),
        .rdaddress (rdaddress),
        .q         (q),
`ifdef POV_READER_BLANK_EN
        .blank     (blank),
`endif
        .led_sdata (led_sdata),
        .led_sclk  (led_sclk),
        .led_latch (led_latch),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Issues one column tick and watches the whole column at negedges; n counts edges since E0.
    task automatic run_column(input int exp_addr, input int extra_at, input int index_at,
                              input bit idx_with_tick, input bit blank_on, input string tag);
        logic [DAT_WIDTH-1:0] exp_word;
        logic [DAT_WIDTH-1:0] got;
        logic                 prev_sclk;
        int edges, latch_n, latch_cnt, busy_low_n, ovr_n, ovr_cnt;
        bit addr_moved, restarted;
        exp_word = blank_on ? '0 : mem[exp_addr];
        got = '0; edges = 0; latch_n = -1; latch_cnt = 0; busy_low_n = -1;
        ovr_n = -1; ovr_cnt = 0; addr_moved = 0; restarted = 0;
        blank = blank_on;
        @(negedge clk);
        col_tick   = 1'b1;
        index_tick = idx_with_tick;
        @(negedge clk);
        col_tick   = 1'b0;
        index_tick = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
        check({tag, "_rdaddress"}, 64'(rdaddress), 64'(exp_addr));
        prev_sclk = led_sclk;
        for (int n = 0; n < COL_CYCLES + 20; n++) begin
            if (n == 3) check({tag, "_first_bit"}, 64'(led_sdata), 64'(exp_word[DAT_WIDTH-1]));
            if (led_sclk && !prev_sclk) begin
                got = {got[DAT_WIDTH-2:0], led_sdata};
                edges++;
            end
            prev_sclk = led_sclk;
            if (led_latch) begin
                if (latch_n < 0) latch_n = n;
                latch_cnt++;
            end
            if (!busy && busy_low_n < 0) busy_low_n = n;
            if (busy && busy_low_n >= 0) restarted = 1;
            if (overrun) begin
                ovr_cnt++;
                ovr_n = n;
            end
            if (rdaddress !== ADDR_WIDTH'(exp_addr)) addr_moved = 1;
            col_tick   = (n == extra_at);
            index_tick = (n == index_at);
            @(negedge clk);
        end
        col_tick   = 1'b0;
        index_tick = 1'b0;
        blank      = 1'b0;
        check({tag, "_sclk_edges"}, 64'(edges), 64'(DAT_WIDTH));
        check({tag, "_word"}, 64'(got), 64'(exp_word));
        check({tag, "_latch_cycle"}, 64'(latch_n), 64'(COL_CYCLES - 1));
        check({tag, "_latch_count"}, 64'(latch_cnt), 64'd1);
        check({tag, "_busy_low"}, 64'(busy_low_n), 64'(COL_CYCLES));
        check({tag, "_addr_stable"}, 64'(addr_moved), 64'd0);
        check({tag, "_no_restart"}, 64'(restarted), 64'd0);
        check({tag, "_overrun_count"}, 64'(ovr_cnt), 64'(extra_at >= 0 ? 1 : 0));
        if (extra_at >= 0) check({tag, "_overrun_cycle"}, 64'(ovr_n), 64'(extra_at + 1));
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_WIDTH); i++)
            mem[i] = DAT_WIDTH'({$urandom, $urandom});
        mem[0] = 36'h8_0000_0001;
        ram_addr = '0;
        q = '0;
        blank = 1'b0;

        // Reset held with both ticks asserted.
        rst_n = 1'b0; col_tick = 1'b1; index_tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_outputs", 64'({led_sdata, led_sclk, led_latch, busy, overrun}), 64'd0);
            check("reset_rdaddress", 64'(rdaddress), 64'd0);
        end
        col_tick = 1'b0; index_tick = 1'b0; rst_n = 1'b1;
        idle(2);
        check("idle_busy", 64'(busy), 64'd0);

        // Single column from address 0, then wrap through NUM_COLS with an overrun in the middle.
        run_column(0, -1, -1, 0, 0, "col0");
        exp_ptr = 1;
        run_column(1, -1, -1, 0, 0, "col1");
        run_column(2, 10, -1, 0, 0, "col2_overrun");
        run_column(3, -1, -1, 0, 0, "col3");
        run_column(0, -1, -1, 0, 0, "wrap0");
        exp_ptr = 1;

        // Index while busy: column finishes intact, next fetch is address 0.
        run_column(1, -1, -1, 0, 0, "col1b");
        run_column(2, -1, 100, 0, 0, "col2_index");
        run_column(0, -1, -1, 0, 0, "after_index");
        exp_ptr = 1;

        // Index alone in IDLE, then index together with col_tick.
        @(negedge clk); index_tick = 1'b1;
        @(negedge clk); index_tick = 1'b0;
        run_column(0, -1, -1, 0, 0, "idle_index");
        run_column(0, -1, -1, 1, 0, "index_with_tick");
        run_column(1, -1, -1, 0, 0, "after_both");
        exp_ptr = 2;

        // Reset mid-column aborts with no latch and returns the pointer to 0.
        @(negedge clk); col_tick = 1'b1;
        @(negedge clk); col_tick = 1'b0;
        idle(100);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rdaddress", 64'(rdaddress), 64'd0);
        begin
            int latches = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (led_latch || led_sclk) latches++;
            end
            check("abort_quiet", 64'(latches), 64'd0);
        end
        exp_ptr = 0;
        run_column(0, -1, -1, 0, 0, "post_abort");
        exp_ptr = 1;

        // Randomised columns against the pointer model.
        for (int k = 0; k < 6; k++) begin
            bit idx_idle, idx_tick;
            int addr;
            idle($urandom_range(0, 5));
            idx_idle = ($urandom_range(0, 3) == 0);
            idx_tick = ($urandom_range(0, 3) == 0);
            if (idx_idle) begin
                @(negedge clk); index_tick = 1'b1;
                @(negedge clk); index_tick = 1'b0;
                exp_ptr = 0;
            end
            addr = idx_tick ? 0 : exp_ptr;
            run_column(addr, -1, -1, idx_tick, 0, $sformatf("rand%0d", k));
            exp_ptr = (addr + 1) % NUM_COLS;
        end

`ifdef POV_READER_BLANK_EN
        mem[exp_ptr] = '1;
        run_column(exp_ptr, -1, -1, 0, 1, "blank");
        exp_ptr = (exp_ptr + 1) % NUM_COLS;
        run_column(exp_ptr, -1, -1, 0, 0, "after_blank");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
